// File: rtl/time_set_counter_pkg.sv
// time_set_counter_pkg
// Shared definitions for the time-keeping / time-setting front end:
//   - state_e : set-mode FSM states (RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN)
//   - BCD limit constants used to configure the two-digit counters
package time_set_counter_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } state_e;

    localparam logic [3:0] HR_TENS_MAX    = 4'd2;
    localparam logic [3:0] HR_ONES_AT_MAX = 4'd3;
    localparam logic [3:0] MS_TENS_MAX    = 4'd5;
    localparam logic [3:0] ONES_MAX       = 4'd9;

endpackage

// File: rtl/bcd2_counter.sv
// bcd2_counter
// Two-digit BCD counter with a programmable maximum (e.g. 23 or 59).
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   inc             : advance the count by one this cycle
//   tens, ones      : registered BCD digits
//   carry_out       : high when inc wraps the count from max back to 00
//                     (combinational, same cycle as the wrapping inc)
module bcd2_counter
    import time_set_counter_pkg::*;
#(
    parameter logic [3:0] TENS_MAX    = MS_TENS_MAX,
    parameter logic [3:0] ONES_AT_MAX = ONES_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry_out
);

    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       at_max;

    always_comb begin
        at_max = (tens_q == TENS_MAX) && (ones_q == ONES_AT_MAX);
        tens_d = tens_q;
        ones_d = ones_q;
        if (inc) begin
            if (at_max) begin
                tens_d = 4'd0;
                ones_d = 4'd0;
            end else if (ones_q == ONES_MAX) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens      = tens_q;
    assign ones      = ones_q;
    assign carry_out = inc & at_max;

endmodule

// File: rtl/time_set_counter.sv
// time_set_counter
// 24-hour HH:MM:SS time keeper with a button-driven set mode and per-field
// blink enables for downstream BCD-to-7-segment decoders.
// Ports:
//   clk, rst_n                 : clock (rising edge), async active-low reset
//   btn_mode                   : one-cycle pulse, advance set-mode state
//   btn_inc                    : one-cycle pulse, increment the edited field
//   hr_*/min_*/sec_* (4b each) : BCD time digits
//   en_set_hr/min/sec          : decoder enable per field (0 blanks it)
//   sec_tick                   : one-cycle pulse on each counted second in RUN
module time_set_counter
    import time_set_counter_pkg::*;
#(
    parameter int TICK_DIV  = 50000000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] hr_tens,
    output logic [3:0] hr_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       en_set_hr,
    output logic       en_set_min,
    output logic       en_set_sec,
    output logic       sec_tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;

    logic tick;
    logic inc_acc;
    logic sec_inc, min_inc, hr_inc;
    logic sec_carry, min_carry, hr_carry;

    always_comb begin
        state_d       = state_q;
        presc_d       = '0;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        tick          = 1'b0;

        // Prescaler only advances in RUN; anywhere else it sits at 0 so the
        // first tick after returning to RUN is a full TICK_DIV away.
        if (state_q == RUN) begin
            tick    = (presc_q == TICK_LAST);
            presc_d = tick ? '0 : presc_q + 1'b1;
        end

        if (btn_mode) begin
            case (state_q)
                RUN:     state_d = SET_HR;
                SET_HR:  state_d = SET_MIN;
                SET_MIN: state_d = SET_SEC;
                SET_SEC: state_d = RUN;
                default: state_d = RUN;
            endcase
        end

        if (state_d != RUN) begin
            presc_d = '0;
        end

        // Restart the blink on any state change or accepted increment so the
        // edited field is shown right after it changes.
        if ((state_d != state_q) || inc_acc) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (state_q != RUN) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end else begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end
    end

    // Mode wins over a simultaneous inc; inc is ignored in RUN.
    assign inc_acc = btn_inc & ~btn_mode & (state_q != RUN);

    // Carries only ripple on a RUN tick; set-mode wraps stay within a field.
    assign sec_inc = tick | (inc_acc & (state_q == SET_SEC));
    assign min_inc = (tick & sec_carry) | (inc_acc & (state_q == SET_MIN));
    assign hr_inc  = (tick & min_carry) | (inc_acc & (state_q == SET_HR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            presc_q       <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    bcd2_counter #(
        .TENS_MAX    (MS_TENS_MAX),
        .ONES_AT_MAX (ONES_MAX)
    ) u_sec (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (sec_inc),
        .tens      (sec_tens),
        .ones      (sec_ones),
        .carry_out (sec_carry)
    );

    bcd2_counter #(
        .TENS_MAX    (MS_TENS_MAX),
        .ONES_AT_MAX (ONES_MAX)
    ) u_min (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (min_inc),
        .tens      (min_tens),
        .ones      (min_ones),
        .carry_out (min_carry)
    );

    // Hour carry has no consumer: 23 -> 00 simply wraps the day.
    bcd2_counter #(
        .TENS_MAX    (HR_TENS_MAX),
        .ONES_AT_MAX (HR_ONES_AT_MAX)
    ) u_hr (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (hr_inc),
        .tens      (hr_tens),
        .ones      (hr_ones),
        .carry_out (hr_carry)
    );

    assign en_set_hr  = (state_q != SET_HR)  | blink_phase_q;
    assign en_set_min = (state_q != SET_MIN) | blink_phase_q;
    assign en_set_sec = (state_q != SET_SEC) | blink_phase_q;
    assign sec_tick   = tick;

    // Kept for symmetry with the other fields; nothing downstream uses it.
    logic unused_hr_carry;
    assign unused_hr_carry = hr_carry;

endmodule

// File: tb/tb_time_set_counter.sv
// tb_time_set_counter
// Directed bench for time_set_counter with TICK_DIV=4, BLINK_DIV=3.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_time_set_counter;

    logic       clk;
    logic       rst_n;
    logic       btn_mode;
    logic       btn_inc;
    logic [3:0] hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones;
    logic       en_set_hr, en_set_min, en_set_sec, sec_tick;
    logic [23:0] now_t;

    int checks = 0;
    int errors = 0;

    time_set_counter #(
        .TICK_DIV  (4),
        .BLINK_DIV (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .hr_tens    (hr_tens),
        .hr_ones    (hr_ones),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .en_set_hr  (en_set_hr),
        .en_set_min (en_set_min),
        .en_set_sec (en_set_sec),
        .sec_tick   (sec_tick)
    );

    assign now_t = {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checkers ----------------
    task automatic check_time(input string tag, input logic [23:0] exp_t);
        checks++;
        assert (now_t === exp_t)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, now_t, exp_t);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp_b);
        checks++;
        assert (obs === exp_b)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_b);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_mode();
        btn_mode = 1'b1;
        step(1);
        btn_mode = 1'b0;
    endtask

    task automatic pulse_inc(input int n);
        repeat (n) begin
            btn_inc = 1'b1;
            step(1);
            btn_inc = 1'b0;
        end
    endtask

    task automatic pulse_both();
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        step(1);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n    = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step(3);
        check_time("reset_time", 24'h000000);
        check_bit("reset_tick", sec_tick, 1'b0);
        rst_n = 1'b1;

        // Count a little, then reset asynchronously between edges.
        step(10);
        check_time("pre_reset_count", 24'h000002);
        #3;
        rst_n = 1'b0;
        #1;
        check_time("async_reset_time", 24'h000000);
        check_bit("async_reset_en_hr", en_set_hr, 1'b1);
        check_bit("async_reset_en_min", en_set_min, 1'b1);
        check_bit("async_reset_en_sec", en_set_sec, 1'b1);
        check_bit("async_reset_tick", sec_tick, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 240 cycles: tick on every 4th cycle, ending at one minute.
        check_bit("tick_k0", sec_tick, 1'b0);
        for (int k = 1; k <= 240; k++) begin
            step(1);
            check_bit("tick_cadence", sec_tick, (k % 4) == 3);
        end
        check_time("one_minute", 24'h000100);

        // Preload 23:59:59 through set mode.
        pulse_mode();
        pulse_inc(23);
        pulse_mode();
        pulse_inc(58);
        pulse_mode();
        pulse_inc(59);
        check_time("preload", 24'h235959);
        pulse_mode();
        check_bit("run_en_hr", en_set_hr, 1'b1);
        step(2);
        check_bit("pre_roll_tick_low", sec_tick, 1'b0);
        step(1);
        check_bit("roll_tick", sec_tick, 1'b1);
        check_time("roll_before", 24'h235959);
        step(1);
        check_time("day_rollover", 24'h000000);
        check_bit("roll_tick_after", sec_tick, 1'b0);

        // SET_HR: blink every 3 cycles starting visible, time frozen.
        pulse_mode();
        for (int j = 0; j <= 20; j++) begin
            check_bit("blink_hr", en_set_hr, ((j / 3) % 2) == 0);
            check_bit("blink_min_on", en_set_min, 1'b1);
            check_bit("blink_sec_on", en_set_sec, 1'b1);
            check_bit("frozen_tick", sec_tick, 1'b0);
            step(1);
        end
        check_time("frozen_time", 24'h000000);

        // Hour field wrap, blink restart after inc.
        pulse_inc(23);
        check_time("hr_23", 24'h230000);
        pulse_inc(1);
        check_time("hr_wrap", 24'h000000);
        for (int j = 0; j <= 3; j++) begin
            check_bit("inc_blink_restart", en_set_hr, j < 3);
            step(1);
        end

        // Minute field wrap with no carry into hours.
        pulse_mode();
        pulse_inc(59);
        check_time("min_59", 24'h005900);
        pulse_inc(1);
        check_time("min_wrap", 24'h000000);

        // Mode and inc together: mode wins, minutes untouched.
        pulse_both();
        check_time("mode_beats_inc", 24'h000000);
        check_bit("set_sec_en_sec0", en_set_sec, 1'b1);
        step(3);
        check_bit("set_sec_en_sec3", en_set_sec, 1'b0);
        check_bit("set_sec_en_min3", en_set_min, 1'b1);
        check_bit("set_sec_en_hr3", en_set_hr, 1'b1);

        // Second field wrap with no carry into minutes.
        pulse_inc(59);
        check_time("sec_59", 24'h000059);
        pulse_inc(1);
        check_time("sec_wrap", 24'h000000);
        pulse_inc(9);
        check_time("sec_09", 24'h000009);

        // Back to RUN; inc is ignored there.
        pulse_mode();
        check_bit("run_en_sec", en_set_sec, 1'b1);
        pulse_inc(1);
        check_time("inc_ignored_run", 24'h000009);

        // Mode on a tick cycle: tick applies and SET_HR entered together.
        step(2);
        check_bit("coincident_tick", sec_tick, 1'b1);
        pulse_mode();
        check_time("tick_with_mode", 24'h000010);
        check_bit("tick_with_mode_tick", sec_tick, 1'b0);
        check_bit("tick_with_mode_en_hr0", en_set_hr, 1'b1);
        step(3);
        check_bit("tick_with_mode_en_hr3", en_set_hr, 1'b0);
        check_bit("tick_with_mode_en_min3", en_set_min, 1'b1);
        check_time("tick_with_mode_frozen", 24'h000010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_set_counter.md
Name: time_set_counter

Overview:
Time-keeping and time-setting front end for the clock display. It keeps a 24-hour HH:MM:SS count as six BCD digits. It runs a button-driven set mode and generates per-field blink enables. Each BCD digit and its field enable drive the in/enSet inputs of one downstream BCD-to-7-segment decoder.

Parameters:
TICK_DIV, 50000000, clk cycles per 1 s tick (>=2)
BLINK_DIV, 12500000, clk cycles per blink half-period in set mode (>=2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
btn_mode  input  1  single-cycle pulse (debounced upstream): advance set-mode state
btn_inc  input  1  single-cycle pulse (debounced upstream): increment edited field
hr_tens, hr_ones  output  4 each  hour BCD digits (00-23)
min_tens, min_ones  output  4 each  minute BCD digits (00-59)
sec_tens, sec_ones  output  4 each  second BCD digits (00-59)
en_set_hr, en_set_min, en_set_sec  output  1 each  decoder enSet per field; 0 blanks the field
sec_tick  output  1  one-cycle pulse on each counted second (RUN only)

Behaviour:
- Interface fixed: single clock clk; rst_n asynchronous, active-low; all state registered on clk rising edge.
- Reset (async, any time, including mid-set): state=RUN, all digits 0 (00:00:00), prescaler=0, blink_phase=1, all en_set_*=1, sec_tick=0. Operation resumes on the first clk edge after rst_n rises.
- FSM states: RUN, SET_HR, SET_MIN, SET_SEC. Each btn_mode pulse advances RUN->SET_HR->SET_MIN->SET_SEC->RUN.
- RUN state:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - On the cycle the prescaler equals TICK_DIV-1, sec_tick=1 and the time advances by 1 s, registered on that same edge.
  - BCD carry chain: sec ones 9->0 carries to tens; sec 59->00 carries to min; min 59->00 carries to hr; hr 23->00.
  - btn_inc is ignored.
- SET_* states:
  - Prescaler is held at 0 and sec_tick=0, so time is frozen.
  - btn_inc increments only the edited field by 1 with wrap: hr 23->00, min 59->00, sec 59->00. No carry into other fields.
- Blink:
  - Blink counter runs only in SET_* states and toggles blink_phase every BLINK_DIV cycles.
  - blink_phase and the blink counter are forced to 1/0 on every state entry and on every accepted btn_inc, so the field is visible immediately after a change.
  - The edited field's en_set_* equals blink_phase; all other en_set_* are 1. In RUN all en_set_* are 1.
- Simultaneous events:
  - btn_mode and btn_inc in the same cycle: mode wins, inc is dropped.
  - btn_mode on a RUN tick cycle: the tick is applied and the state moves to SET_HR on the same edge.
  - On SET_SEC->RUN the prescaler restarts at 0, so the first tick arrives TICK_DIV cycles later.
- Digit outputs are always valid BCD (0-9). Tens digits are bounded at 2 (hr) and 5 (min/sec).
- Latency: one cycle from button pulse or terminal prescaler count to updated outputs.

Decomposition:
- Shared package: state enum (RUN, SET_HR, SET_MIN, SET_SEC) and BCD limit constants (HR_TENS_MAX=2, HR_ONES_AT_MAX=3, MS_TENS_MAX=5, ONES_MAX=9).
- Sub-module bcd2_counter: two-digit BCD counter with inc input, programmable max (23 or 59), wrap and carry_out; instantiated three times.
- Prescaler, blink timer and FSM stay in the top level.

Test Plan:
- Reset/blink (TICK_DIV=4, BLINK_DIV=3): assert rst_n=0 mid-count -> digits 00:00:00, en_set_*=1, sec_tick=0 asynchronously; release and run 240 cycles -> 00:01:00, with sec_tick every 4th cycle.
- Preload 23:59:59 via set mode, return to RUN, wait 4 cycles -> 00:00:00 on the tick edge, with sec_tick=1 that cycle.
- btn_mode once -> SET_HR; en_set_hr toggles every 3 cycles starting at 1; en_set_min=en_set_sec=1; time frozen over 20 cycles.
- In SET_HR at 23, pulse btn_inc -> 00, min/sec unchanged, en_set_hr forced to 1 for the next 3 cycles. In SET_MIN at 59, btn_inc -> 00, hr unchanged.
- btn_mode and btn_inc in the same cycle in SET_MIN -> state SET_SEC, minutes unchanged. btn_inc in RUN -> no change.
- btn_mode coincident with a RUN tick at 00:00:09 -> 00:00:10 and state SET_HR on the same edge.
